// File: rtl/half_subtractor_unit.sv
// Registered bit-parallel half subtractor: each lane computes A - B into a
// difference and borrow-out bit, presented one clock after the operands.
module half_subtractor_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Diff,
  output logic [WIDTH-1:0] Bor
);

  // Data registers load only on a valid beat, so idle operands never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Diff      <= '0;
      Bor       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Diff <= A ^ B;
        Bor  <= ~A & B;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor_unit.sv
// Scoreboard bench: a WIDTH=4 and a WIDTH=1 instance share stimulus; expected
// results are queued at issue time and popped by a monitor on each valid output.
module tb_half_subtractor_unit;

  typedef struct packed {
    logic [3:0] diff;
    logic [3:0] bor;
  } exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic [3:0] bor;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid4;
  logic [3:0] diff4;
  logic [3:0] bor4;
  logic       out_valid1;
  logic [0:0] diff1;
  logic [0:0] bor1;

  int checks;
  int failures;
  exp_t exp_q[$];

  half_subtractor_unit #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .out_valid (out_valid4),
    .Diff      (diff4),
    .Bor       (bor4)
  );

  half_subtractor_unit #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a[0:0]),
    .B         (b[0:0]),
    .out_valid (out_valid1),
    .Diff      (diff1),
    .Bor       (bor1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic check_nib(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Directed check of both instances against explicit expected values.
  task automatic checkOutput(input string name, input logic exp_valid,
                             input logic [3:0] exp_diff, input logic [3:0] exp_bor);
    check_bit({name, ".out_valid4"}, out_valid4, exp_valid);
    check_nib({name, ".diff4"}, diff4, exp_diff);
    check_nib({name, ".bor4"}, bor4, exp_bor);
    check_bit({name, ".out_valid1"}, out_valid1, exp_valid);
    check_bit({name, ".diff1"}, diff1[0], exp_diff[0]);
    check_bit({name, ".bor1"}, bor1[0], exp_bor[0]);
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] va, input logic [3:0] vb,
                               input logic [3:0] exp_diff, input logic [3:0] exp_bor);
    exp_t e;
    @(negedge clk);
    in_valid = valid;
    a = va;
    b = vb;
    if (valid) begin
      e.diff = exp_diff;
      e.bor  = exp_bor;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (out_valid4 || out_valid1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: got out_valid4=%b out_valid1=%b, expected no output",
                 out_valid4, out_valid1);
      end else begin
        e = exp_q.pop_front();
        check_bit("sb.out_valid4", out_valid4, 1'b1);
        check_bit("sb.out_valid1", out_valid1, 1'b1);
        check_nib("sb.diff4", diff4, e.diff);
        check_nib("sb.bor4", bor4, e.bor);
        check_bit("sb.diff1", diff1[0], e.diff[0]);
        check_bit("sb.bor1", bor1[0], e.bor[0]);
      end
    end
  end

  vec_t stream[10] = '{
    '{4'b0000, 4'b0000, 4'b0000, 4'b0000},
    '{4'b0000, 4'b1111, 4'b1111, 4'b1111},
    '{4'b1111, 4'b0000, 4'b1111, 4'b0000},
    '{4'b1111, 4'b1111, 4'b0000, 4'b0000},
    '{4'b0011, 4'b0101, 4'b0110, 4'b0100},
    '{4'b1010, 4'b0110, 4'b1100, 4'b0100},
    '{4'b0000, 4'b0001, 4'b0001, 4'b0001},
    '{4'b0111, 4'b1000, 4'b1111, 4'b1000},
    '{4'b1100, 4'b1010, 4'b0110, 4'b0010},
    '{4'b0101, 4'b1010, 4'b1111, 4'b1010}
  };

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'b1111;
    b        = 4'b1111;

    // Reset held with live operands: outputs must stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset", 1'b0, 4'b0000, 4'b0000);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table on every lane, then back-to-back mixed-lane vectors.
    foreach (stream[i])
      applyStimulus(1'b1, stream[i].a, stream[i].b, stream[i].diff, stream[i].bor);

    // Hold: idle cycles with X operands keep the last result.
    applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("hold", 1'b0, 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'bxxxx, 4'bxxxx, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("hold_x", 1'b0, 4'b1111, 4'b0000);

    // Asynchronous reset between edges while a result is on the outputs.
    applyStimulus(1'b1, 4'b0101, 4'b1010, 4'b1111, 4'b1010);
    @(posedge clk);
    #1;
    checkOutput("pre_reset", 1'b1, 4'b1111, 4'b1010);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("async_reset", 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("reset_held", 1'b0, 4'b0000, 4'b0000);
    rst_n = 1'b1;

    // Recovery after reset.
    applyStimulus(1'b1, 4'b0011, 4'b0101, 4'b0110, 4'b0100);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++)
      @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
